// File: rtl/ldst_control_sequencer.sv
`default_nettype none
// ============================================================================
// ldst_control_sequencer : Moore control unit (fetch, ld/ldi/st/addi/nop/halt)
// Rev 1.0
// ============================================================================
module ldst_control_sequencer #(
  parameter int unsigned MEM_LAT = 1,
  parameter logic [4:0]  OP_LD   = 5'b00000,
  parameter logic [4:0]  OP_LDI  = 5'b00001,
  parameter logic [4:0]  OP_ST   = 5'b00010,
  parameter logic [4:0]  OP_ADDI = 5'b01100,
  parameter logic [4:0]  OP_NOP  = 5'b11010,
  parameter logic [4:0]  OP_HALT = 5'b11011
) (
  input  logic        Clock_i,
  input  logic        Reset_i,
  input  logic        Stop_i,
  input  logic [31:0] IR_i,
  output logic        PCout_o,
  output logic        MARin_o,
  output logic        IncPC_o,
  output logic        Zin_o,
  output logic        PCin_o,
  output logic        ZLOout_o,
  output logic        Read_o,
  output logic        MDRin_o,
  output logic        MDRout_o,
  output logic        IRin_o,
  output logic        Gra_o,
  output logic        Grb_o,
  output logic        Rin_o,
  output logic        Rout_o,
  output logic        BAout_o,
  output logic        Cout_o,
  output logic        Yin_o,
  output logic        write_o,
  output logic        ADD_o,
  output logic        Run_o,
  output logic [3:0]  Tstep_o
);

  typedef enum logic [4:0] {
    S_RESET, S_T0, S_T1, S_T2,
    S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
    S_LDI_T3, S_LDI_T4, S_LDI_T5,
    S_ST_T3, S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
    S_ADDI_T3, S_ADDI_T4, S_ADDI_T5,
    S_HALT
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_e     state_q, state_d, next_instr;
  logic [2:0] wait_q, wait_d;
  logic       wait_done, enter_mem;
  logic       ir_unused;

  assign ir_unused = ^IR_i[26:0];
  assign wait_done = (wait_q == 3'd0);
  // Final step of every instruction: Stop diverts the machine to HALT
  assign next_instr = Stop_i ? S_HALT : S_T0;

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= S_RESET;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:   state_d = S_T0;
      S_T0:      state_d = S_T1;
      S_T1:      if (wait_done) state_d = S_T2;
      S_T2: begin
        case (IR_i[31:27])
          OP_LD:   state_d = S_LD_T3;
          OP_LDI:  state_d = S_LDI_T3;
          OP_ST:   state_d = S_ST_T3;
          OP_ADDI: state_d = S_ADDI_T3;
          OP_HALT: state_d = S_HALT;
          default: state_d = next_instr;
        endcase
      end
      S_LD_T3:   state_d = S_LD_T4;
      S_LD_T4:   state_d = S_LD_T5;
      S_LD_T5:   state_d = S_LD_T6;
      S_LD_T6:   if (wait_done) state_d = S_LD_T7;
      S_LD_T7:   state_d = next_instr;
      S_LDI_T3:  state_d = S_LDI_T4;
      S_LDI_T4:  state_d = S_LDI_T5;
      S_LDI_T5:  state_d = next_instr;
      S_ST_T3:   state_d = S_ST_T4;
      S_ST_T4:   state_d = S_ST_T5;
      S_ST_T5:   state_d = S_ST_T6;
      S_ST_T6:   state_d = S_ST_T7;
      S_ST_T7:   if (wait_done) state_d = next_instr;
      S_ADDI_T3: state_d = S_ADDI_T4;
      S_ADDI_T4: state_d = S_ADDI_T5;
      S_ADDI_T5: state_d = next_instr;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RESET;
    endcase
  end

  assign enter_mem = (state_d != state_q) &&
                     ((state_d == S_T1) || (state_d == S_LD_T6) || (state_d == S_ST_T7));

  always_comb begin
    wait_d = wait_q;
    if (enter_mem)       wait_d = LAT_M1;
    else if (!wait_done) wait_d = wait_q - 3'd1;
  end

  always_comb begin
    PCout_o  = 1'b0; MARin_o  = 1'b0; IncPC_o = 1'b0; Zin_o   = 1'b0;
    PCin_o   = 1'b0; ZLOout_o = 1'b0; Read_o  = 1'b0; MDRin_o = 1'b0;
    MDRout_o = 1'b0; IRin_o   = 1'b0; Gra_o   = 1'b0; Grb_o   = 1'b0;
    Rin_o    = 1'b0; Rout_o   = 1'b0; BAout_o = 1'b0; Cout_o  = 1'b0;
    Yin_o    = 1'b0; write_o  = 1'b0; ADD_o   = 1'b0;
    Run_o    = 1'b1; Tstep_o  = 4'd0;
    case (state_q)
      S_T0: begin
        PCout_o = 1'b1; MARin_o = 1'b1; IncPC_o = 1'b1; Zin_o = 1'b1; Tstep_o = 4'd1;
      end
      S_T1: begin
        ZLOout_o = 1'b1; PCin_o = 1'b1; Read_o = 1'b1; MDRin_o = 1'b1; Tstep_o = 4'd2;
      end
      S_T2: begin
        MDRout_o = 1'b1; IRin_o = 1'b1; Tstep_o = 4'd3;
      end
      S_LD_T3, S_LDI_T3, S_ST_T3: begin
        Grb_o = 1'b1; BAout_o = 1'b1; Yin_o = 1'b1; Tstep_o = 4'd4;
      end
      S_ADDI_T3: begin
        Grb_o = 1'b1; Rout_o = 1'b1; Yin_o = 1'b1; Tstep_o = 4'd4;
      end
      S_LD_T4, S_LDI_T4, S_ST_T4, S_ADDI_T4: begin
        Cout_o = 1'b1; ADD_o = 1'b1; Zin_o = 1'b1; Tstep_o = 4'd5;
      end
      S_LD_T5, S_ST_T5: begin
        ZLOout_o = 1'b1; MARin_o = 1'b1; Tstep_o = 4'd6;
      end
      S_LDI_T5, S_ADDI_T5: begin
        ZLOout_o = 1'b1; Gra_o = 1'b1; Rin_o = 1'b1; Tstep_o = 4'd6;
      end
      S_LD_T6: begin
        Read_o = 1'b1; MDRin_o = 1'b1; Tstep_o = 4'd7;
      end
      S_ST_T6: begin
        Gra_o = 1'b1; Rout_o = 1'b1; MDRin_o = 1'b1; Tstep_o = 4'd7;
      end
      S_LD_T7: begin
        MDRout_o = 1'b1; Gra_o = 1'b1; Rin_o = 1'b1; Tstep_o = 4'd8;
      end
      S_ST_T7: begin
        write_o = 1'b1; Tstep_o = 4'd8;
      end
      S_HALT: begin
        Run_o = 1'b0; Tstep_o = 4'd15;
      end
      default: Run_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ldst_control_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ldst_control_sequencer : scoreboard bench, one directed program per MEM_LAT
// Rev 1.0
// ============================================================================
module tb_ldst_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] e;
    string       tag;
  } exp_t;

  // Observation order: {PCout..Run (20 bits), Tstep}
  localparam logic [19:0] B_PCOUT  = 20'h80000, B_MARIN  = 20'h40000;
  localparam logic [19:0] B_INCPC  = 20'h20000, B_ZIN    = 20'h10000;
  localparam logic [19:0] B_PCIN   = 20'h08000, B_ZLOOUT = 20'h04000;
  localparam logic [19:0] B_READ   = 20'h02000, B_MDRIN  = 20'h01000;
  localparam logic [19:0] B_MDROUT = 20'h00800, B_IRIN   = 20'h00400;
  localparam logic [19:0] B_GRA    = 20'h00200, B_GRB    = 20'h00100;
  localparam logic [19:0] B_RIN    = 20'h00080, B_ROUT   = 20'h00040;
  localparam logic [19:0] B_BAOUT  = 20'h00020, B_COUT   = 20'h00010;
  localparam logic [19:0] B_YIN    = 20'h00008, B_WRITE  = 20'h00004;
  localparam logic [19:0] B_ADD    = 20'h00002, B_RUN    = 20'h00001;

  localparam logic [23:0] E_RST  = 24'h0;
  localparam logic [23:0] E_HALT = {20'h0, 4'd15};
  localparam logic [23:0] E_T0   = {B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_RUN, 4'd1};
  localparam logic [23:0] E_T1   = {B_ZLOOUT | B_PCIN | B_READ | B_MDRIN | B_RUN, 4'd2};
  localparam logic [23:0] E_T2   = {B_MDROUT | B_IRIN | B_RUN, 4'd3};
  localparam logic [23:0] E_X3   = {B_GRB | B_BAOUT | B_YIN | B_RUN, 4'd4};
  localparam logic [23:0] E_A3   = {B_GRB | B_ROUT | B_YIN | B_RUN, 4'd4};
  localparam logic [23:0] E_X4   = {B_COUT | B_ADD | B_ZIN | B_RUN, 4'd5};
  localparam logic [23:0] E_MAR5 = {B_ZLOOUT | B_MARIN | B_RUN, 4'd6};
  localparam logic [23:0] E_GR5  = {B_ZLOOUT | B_GRA | B_RIN | B_RUN, 4'd6};
  localparam logic [23:0] E_LD6  = {B_READ | B_MDRIN | B_RUN, 4'd7};
  localparam logic [23:0] E_ST6  = {B_GRA | B_ROUT | B_MDRIN | B_RUN, 4'd7};
  localparam logic [23:0] E_LD7  = {B_MDROUT | B_GRA | B_RIN | B_RUN, 4'd8};
  localparam logic [23:0] E_ST7  = {B_WRITE | B_RUN, 4'd8};

  localparam logic [31:0] IR_LD   = 32'h0088_0075;
  localparam logic [31:0] IR_ST   = 32'h1000_0090;
  localparam logic [31:0] IR_ADDI = 32'h6088_0005;
  localparam logic [31:0] IR_LDI  = 32'h0880_0010;
  localparam logic [31:0] IR_UNK  = 32'hA800_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  for (genvar k = 0; k < 3; k++) begin : g_lat
    localparam int L = k + 1;

    logic        rst, stop;
    logic [31:0] ir;
    logic        pcout, marin, incpc, zin, pcin, zloout, read, mdrin, mdrout, irin;
    logic        gra, grb, rin, rout, baout, cout, yin, wr, add, run;
    logic [3:0]  tstep;
    logic [23:0] obs;
    exp_t        q[$];
    bit          done = 1'b0;

    ldst_control_sequencer #(.MEM_LAT(L)) u_dut (
      .Clock_i (clk),    .Reset_i (rst),    .Stop_i  (stop),   .IR_i    (ir),
      .PCout_o (pcout),  .MARin_o (marin),  .IncPC_o (incpc),  .Zin_o   (zin),
      .PCin_o  (pcin),   .ZLOout_o(zloout), .Read_o  (read),   .MDRin_o (mdrin),
      .MDRout_o(mdrout), .IRin_o  (irin),   .Gra_o   (gra),    .Grb_o   (grb),
      .Rin_o   (rin),    .Rout_o  (rout),   .BAout_o (baout),  .Cout_o  (cout),
      .Yin_o   (yin),    .write_o (wr),     .ADD_o   (add),    .Run_o   (run),
      .Tstep_o (tstep)
    );

    assign obs = {pcout, marin, incpc, zin, pcin, zloout, read, mdrin, mdrout, irin,
                  gra, grb, rin, rout, baout, cout, yin, wr, add, run, tstep};

    // One expected entry per cycle; inputs changed after a call act on that cycle's closing edge
    task automatic cyc(input logic [23:0] e, input string tag, input int n = 1);
      exp_t x;
      repeat (n) begin
        @(posedge clk);
        #1;
        x.e = e;
        x.tag = tag;
        q.push_back(x);
      end
    endtask

    task automatic reset_pulse(input string tag);
      exp_t x;
      @(posedge clk);
      #1;
      rst = 1'b1;
      x.e = E_RST;
      x.tag = tag;
      q.push_back(x);
      cyc(E_RST, "reset_hold");
      rst = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] v);
      cyc(E_T0, "T0");
      ir = v;
      cyc(E_T1, "T1", L);
      cyc(E_T2, "T2");
    endtask

    task automatic run_ld(input bit stop_in_t4);
      fetch(IR_LD);
      cyc(E_X3, "ld_T3");
      cyc(E_X4, "ld_T4");
      if (stop_in_t4) stop = 1'b1;
      cyc(E_MAR5, "ld_T5");
      cyc(E_LD6, "ld_T6", L);
      cyc(E_LD7, "ld_T7");
    endtask

    initial begin
      rst = 1'b1;
      stop = 1'b0;
      ir = IR_LD;
      cyc(E_RST, "reset", 2);
      rst = 1'b0;
      // ld cut short by reset inside its memory step
      fetch(IR_LD);
      cyc(E_X3, "ld_T3");
      cyc(E_X4, "ld_T4");
      cyc(E_MAR5, "ld_T5");
      cyc(E_LD6, "ld_T6");
      reset_pulse("reset_mid_ld");
      run_ld(1'b0);
      fetch(IR_ST);
      cyc(E_X3, "st_T3");
      cyc(E_X4, "st_T4");
      cyc(E_MAR5, "st_T5");
      cyc(E_ST6, "st_T6");
      cyc(E_ST7, "st_T7", L);
      fetch(IR_ADDI);
      cyc(E_A3, "addi_T3");
      cyc(E_X4, "addi_T4");
      cyc(E_GR5, "addi_T5");
      fetch(IR_LDI);
      cyc(E_X3, "ldi_T3");
      cyc(E_X4, "ldi_T4");
      cyc(E_GR5, "ldi_T5");
      fetch(IR_UNK);
      fetch(IR_NOP);
      // Stop raised mid-ld must let the ld finish, then halt
      run_ld(1'b1);
      cyc(E_HALT, "halt_stop");
      stop = 1'b0;
      cyc(E_HALT, "halt_stop", 19);
      reset_pulse("reset_in_halt");
      fetch(IR_HALT);
      cyc(E_HALT, "halt_op", 20);
      reset_pulse("reset_in_halt2");
      stop = 1'b1;
      fetch(IR_NOP);
      cyc(E_HALT, "halt_nop_stop", 3);
      @(negedge clk);
      @(negedge clk);
      done = 1'b1;
    end

    initial begin
      exp_t x;
      forever begin
        @(negedge clk);
        if (q.size() > 0) begin
          x = q.pop_front();
          checks++;
          if (obs !== x.e) begin
            errors++;
            $display("FAIL lat%0d %s: got %h expected %h", L, x.tag, obs, x.e);
          end
        end
      end
    end

    always @(negedge clk) begin
      if (rst === 1'b0) begin
        checks++;
        if ((3'(pcout) + 3'(zloout) + 3'(mdrout) + 3'(rout) + 3'(baout) + 3'(cout)) > 3'd1) begin
          errors++;
          $display("FAIL lat%0d: more than one bus driver active, obs %h", L, obs);
        end
        if (rin && rout) begin
          errors++;
          $display("FAIL lat%0d: Rin and Rout both active, obs %h", L, obs);
        end
      end
    end
  end

  initial begin
    wait (g_lat[0].done && g_lat[1].done && g_lat[2].done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors != 0 || checks == 0) begin
      $display("FAIL: %0d errors in %0d checks", errors, checks);
      $fatal(1);
    end else begin
      $display("PASS");
    end
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
